program_loader_arbiter: RTL and testbench

- Owns the control word and the shared 8-bit bus between power-up and program start.
- While a program is loaded, it holds the CPU core in reset and accepts bytes on a valid/ready stream.
- Each byte is written into the 16x8 RAM through the MAR/RAM strobes in a fixed 3-step sequence.
- When loading ends, it hands the control word and bus to the CPU control block and releases the core. It sits between the control block output and the datapath control inputs.

---
 rtl/program_loader_arbiter.sv | 148 ++++++++++++++
 tb/tb_program_loader_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_arbiter.sv
// Program loader: holds the CPU in reset, streams bytes into RAM via MAR/RAM strobes, then hands over.
// Optional LOADER_ZERO_FILL_EN: an early prog_last zero-fills the remaining addresses before RUN.
module program_loader_arbiter #(
   parameter int                 ADDR_W    = 4,
   parameter int                 DATA_W    = 8,
   parameter int                 CTRL_W    = 15,
   parameter logic [CTRL_W-1:0]  CTRL_IDLE = 15'h0FE3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_req,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              prog_last,
   input  logic [CTRL_W-1:0] ctrl_cpu,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              cpu_rst_n,
   output logic [ADDR_W:0]   load_count,
   output logic              load_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_RUN   = 3'd5
   } state_t;

   localparam logic [CTRL_W-1:0] ONE       = {{(CTRL_W-1){1'b0}}, 1'b1};
   localparam logic [CTRL_W-1:0] MAR_A_N   = ONE << 11;
   localparam logic [CTRL_W-1:0] MAR_D_N   = ONE << 10;
   localparam logic [CTRL_W-1:0] RAM_EN_N  = ONE << 9;
   localparam logic [CTRL_W-1:0] RAM_WR_N  = ONE << 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

   state_t              state, state_n;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   byte_q;
   logic                fill_active;
   logic [CTRL_W-1:0]   ctrl_d;
   logic [DATA_W-1:0]   bus_d;
   logic                oe_d;

   assign in_ready  = (state == S_WAIT);
   assign cpu_rst_n = (state == S_RUN);
   assign load_done = (state == S_RUN);

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = prog_req ? S_WAIT : S_RUN;
         S_WAIT: begin
            if (in_valid) begin
               state_n = S_ADDR;
            end else if (prog_last) begin
`ifdef LOADER_ZERO_FILL_EN
               state_n = S_ADDR;
`else
               state_n = S_RUN;
`endif
            end
         end
         S_ADDR:  state_n = S_DATA;
         S_DATA:  state_n = S_WRITE;
         S_WRITE: begin
            // The last address always ends loading, so addr never wraps.
            if (addr == LAST_ADDR) state_n = S_RUN;
            else if (fill_active)  state_n = S_ADDR;
            else                   state_n = S_WAIT;
         end
         S_RUN:   state_n = S_RUN;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr       <= '0;
         load_count <= '0;
         byte_q     <= '0;
      end else begin
         state <= state_n;
         if (state == S_WAIT && in_valid) begin
            byte_q <= in_data;
         end else if (state == S_WAIT && prog_last) begin
            byte_q <= '0;
         end
         if (state == S_WRITE) begin
            if (addr != LAST_ADDR)     addr       <= addr + ADDR_ONE;
            if (load_count != CNT_MAX) load_count <= load_count + CNT_ONE;
         end
      end
   end

`ifdef LOADER_ZERO_FILL_EN
   logic fill_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_q <= 1'b0;
      end else if (state == S_WAIT && !in_valid && prog_last) begin
         fill_q <= 1'b1;
      end
   end

   assign fill_active = fill_q;
`else
   assign fill_active = 1'b0;
`endif

   always_comb begin
      ctrl_d = CTRL_IDLE;
      bus_d  = '0;
      oe_d   = 1'b0;
      case (state)
         S_ADDR: begin
            ctrl_d = CTRL_IDLE & ~MAR_A_N;
            bus_d  = {{(DATA_W-ADDR_W){1'b0}}, addr};
            oe_d   = 1'b1;
         end
         S_DATA: begin
            ctrl_d = CTRL_IDLE & ~MAR_D_N;
            bus_d  = byte_q;
            oe_d   = 1'b1;
         end
         S_WRITE: ctrl_d = (CTRL_IDLE | RAM_EN_N) & ~RAM_WR_N;
         S_RUN:   ctrl_d = ctrl_cpu;
         default: ctrl_d = CTRL_IDLE;
      endcase
   end

   // Registered on the falling edge so strobes are settled before the datapath's rising edge.
   always_ff @(negedge clk) begin
      ctrl_out <= ctrl_d;
      bus_out  <= bus_d;
      bus_oe   <= oe_d;
   end

endmodule

// File: tb/tb_program_loader_arbiter.sv
// Randomized bench for program_loader_arbiter: a behavioural MAR/RAM model consumes the strobes and
// a scoreboard of expected {addr,data} writes checks every RAM write.
module tb_program_loader_arbiter;

  localparam logic [14:0] CTRL_IDLE = 15'h0FE3;
  localparam logic [14:0] W_ADDR    = 15'h07E3;
  localparam logic [14:0] W_DATA    = 15'h0BE3;
  localparam logic [14:0] W_WRITE   = 15'h0EE3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_req = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        prog_last = 1'b0;
  logic [14:0] ctrl_cpu = 15'h2800;
  logic [14:0] ctrl_out;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        cpu_rst_n;
  logic [4:0]  load_count;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [16];
  logic [7:0]  exp_mem [16];
  logic [3:0]  mar;
  logic [7:0]  mdr;
  logic [14:0] last_word = 15'h0FE3;
  logic [11:0] exp_q[$];
  int          n_acc = 0;

  program_loader_arbiter dut (
    .clk(clk), .rst_n(rst_n), .prog_req(prog_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .prog_last(prog_last),
    .ctrl_cpu(ctrl_cpu), .ctrl_out(ctrl_out), .bus_out(bus_out), .bus_oe(bus_oe),
    .cpu_rst_n(cpu_rst_n), .load_count(load_count), .load_done(load_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // datapath model and scoreboard, sampled after the falling edge that updates ctrl_out
  always @(negedge clk) begin
    #1;
    if (load_done !== 1'b1) begin
      case (ctrl_out)
        W_ADDR: begin
          check_eq("addr_oe", bus_oe, 1);
          mar = bus_out[3:0];
        end
        W_DATA: begin
          check_eq("seq_data", last_word, W_ADDR);
          check_eq("data_oe", bus_oe, 1);
          mdr = bus_out;
        end
        W_WRITE: begin
          check_eq("seq_write", last_word, W_DATA);
          check_eq("write_oe", bus_oe, 0);
          if (exp_q.size() == 0) begin
            check_eq("wr_unexpected", 1, 0);
          end else begin
            check_eq("wr_addr_data", {mar, mdr}, exp_q.pop_front());
          end
          mem[mar] = mdr;
        end
        default: ;
      endcase
    end
    if (in_ready === 1'b1) begin
      check_eq("wait_ctrl", ctrl_out, CTRL_IDLE);
      check_eq("wait_oe", bus_oe, 0);
    end
    if (load_done === 1'b1) check_eq("run_ctrl", ctrl_out, ctrl_cpu);
    last_word = ctrl_out;
  end

  // driver tasks
  task automatic do_reset(input bit req);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; prog_last = 1'b0; prog_req = req;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check_eq("rst_ctrl", ctrl_out, CTRL_IDLE);
    check_eq("rst_oe", bus_oe, 0);
    check_eq("rst_bus", bus_out, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_cpu_rst_n", cpu_rst_n, 0);
    check_eq("rst_done", load_done, 0);
    check_eq("rst_count", load_count, 0);
    exp_q.delete();
    n_acc = 0;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit with_last);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data = d; in_valid = 1'b1; prog_last = with_last;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check_eq("accept_timeout", 0, 1);
      in_valid = 1'b0; prog_last = 1'b0;
      return;
    end
    exp_q.push_back({n_acc[3:0], d});
    exp_mem[n_acc[3:0]] = d;
    n_acc++;
    @(posedge clk); #1;
    in_valid = 1'b0; prog_last = 1'b0;
  endtask

  task automatic end_prog();
    int n;
    @(negedge clk);
    prog_last = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("last_wait_ready", in_ready, 1);
    @(posedge clk); #1;
    prog_last = 1'b0;
`ifdef LOADER_ZERO_FILL_EN
    for (int a = n_acc; a < 16; a++) begin
      exp_q.push_back({a[3:0], 8'h00});
      exp_mem[a] = 8'h00;
    end
    n_acc = 16;
`endif
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("run_timeout", load_done, 1);
    @(negedge clk); #2;
    check_eq("exp_drained", exp_q.size(), 0);
    check_eq("load_count", load_count, n_acc);
    check_eq("run_cpu_rst_n", cpu_rst_n, 1);
    check_eq("run_ready", in_ready, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) check_eq(tag, {i[3:0], mem[i]}, {i[3:0], exp_mem[i]});
  endtask

  initial begin
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'hA5;
      exp_mem[i] = 8'hA5;
    end

    // no program: straight to RUN
    do_reset(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("nop_done", load_done, 1);
    check_eq("nop_cpu_rst_n", cpu_rst_n, 1);
    check_eq("nop_count", load_count, 0);
    @(negedge clk); #2;
    check_eq("nop_ctrl", ctrl_out, 15'h2800);
    repeat (8) begin
      @(posedge clk); #1;
      ctrl_cpu = 15'($urandom);
      @(negedge clk); #2;
      check_eq("run_ctrl_rand", ctrl_out, ctrl_cpu);
    end
    ctrl_cpu = 15'h2800;

    // full back-to-back load
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 0, 1'b0);
    wait_run();
    check_mem("full_mem");

    // backpressure and early end after 3 bytes
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 8, 1'b0);
    end_prog();
    wait_run();
    check_mem("early_mem");

    // valid and prog_last together: byte wins
    do_reset(1'b1);
    send_byte(8'($urandom), 0, 1'b1);
    check_eq("both_no_run", load_done, 0);
    for (int i = 1; i < 16; i++) send_byte(8'($urandom), $urandom_range(0, 4), 1'b0);
    wait_run();
    check_mem("both_mem");

    // reset during the WRITE of byte 5
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check_eq("midrst_ctrl", ctrl_out, CTRL_IDLE);
    check_eq("midrst_cpu_rst_n", cpu_rst_n, 0);
    check_eq("midrst_count", load_count, 0);
    check_eq("midrst_exp", exp_q.size(), 0);
    do_reset(1'b1);
    d = 8'($urandom);
    send_byte(d, 0, 1'b0);
    end_prog();
    wait_run();
    check_eq("reload_addr0", mem[0], d);
    check_mem("reload_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
